// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants and state encoding for the BNN layer scheduler.
// Holds the default geometry of the conv/FC engine and the weight-memory map.
package bnn_pkg;

  // Conv output side; one image is BNN_OUT_DIM*BNN_OUT_DIM windows.
  localparam int BNN_OUT_DIM   = 9;
  // FC steps per image.
  localparam int BNN_FC_NUM    = 10;

  // Weight-memory map: slot 0 is the conv kernel set, FC sets follow.
  localparam int BNN_WADDR_W   = 5;
  localparam int BNN_KSET_ADDR = 0;
  localparam int BNN_FC_WBASE  = 1;

  // Output buffer address widths.
  localparam int BNN_FADDR_W   = 7;
  localparam int BNN_RADDR_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KLOAD = 3'd1,
    ST_CONV  = 3'd2,
    ST_FC    = 3'd3,
    ST_DRAIN = 3'd4
  } bnn_state_e;

endpackage

// File: rtl/bnn_wr_addr_gen.sv
// bnn_wr_addr_gen: turns a datapath result valid into a registered
// (write strobe, address) pair. The address is the number of writes already
// done for this image, so strobe and address leave the block together one
// cycle after the valid. The counter stops at DEPTH; extra valids are dropped.
module bnn_wr_addr_gen #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 81
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en,
  input  logic              vld_in,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] cnt
);

  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

  logic              we_q,   we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q,  cnt_d;

  // Accept a valid while enabled and not full; clear restarts the image count.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && vld_in && (cnt_q != DEPTH_C)) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      cnt_d  = cnt_q + ADDR_W'(1);
    end
  end

  // Strobe, address and count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign we   = we_q;
  assign addr = addr_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/bnn_layer_sched.sv
// bnn_layer_sched: per-image sequencer for the BNN conv/FC datapath.
// KLOAD fetches the conv kernel set, CONV feeds OUT_DIM*OUT_DIM windows,
// FC answers the datapath's weight requests with FC weight-set reads, and
// DRAIN waits for the last FC result before pulsing done.
// Build option: define BNN_SCHED_PERF_EN to add the perf_cycles output.
module bnn_layer_sched
  import bnn_pkg::*;
#(
  parameter int OUT_DIM  = BNN_OUT_DIM,
  parameter int FC_NUM   = BNN_FC_NUM,
  parameter int WADDR_W  = BNN_WADDR_W,
  parameter int FC_WBASE = BNN_FC_WBASE,
  parameter int FADDR_W  = BNN_FADDR_W,
  parameter int RADDR_W  = BNN_RADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               win_valid,
  output logic               win_ready,
  output logic               dp_conv_valid,
  input  logic               dp_weight_req,
  input  logic               dp_out_conv_valid,
  input  logic               dp_out_fc_valid,
  output logic               wmem_rd,
  output logic [WADDR_W-1:0] wmem_addr,
  output logic               fbuf_we,
  output logic [FADDR_W-1:0] fbuf_addr,
  output logic               res_we,
  output logic [RADDR_W-1:0] res_addr,
  output logic               err
`ifdef BNN_SCHED_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);

  localparam int                 WIN_NUM   = OUT_DIM * OUT_DIM;
  localparam logic [FADDR_W-1:0] WIN_LAST  = FADDR_W'(WIN_NUM - 1);
  localparam logic [FADDR_W-1:0] WIN_END   = FADDR_W'(WIN_NUM);
  localparam logic [RADDR_W-1:0] FC_END    = RADDR_W'(FC_NUM);
  localparam logic [WADDR_W-1:0] FC_BASE_A = WADDR_W'(FC_WBASE);
  localparam logic [WADDR_W-1:0] KSET_A    = WADDR_W'(BNN_KSET_ADDR);

  bnn_state_e         state_q,   state_d;
  logic [FADDR_W-1:0] win_cnt_q, win_cnt_d;
  logic [RADDR_W-1:0] fc_idx_q,  fc_idx_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;

  logic               start_acc;
  logic               cnt_clr;
  logic [FADDR_W-1:0] f_cnt;
  logic [RADDR_W-1:0] res_cnt;

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign dp_conv_valid = win_ready;

  // A start on the cycle done is shown is dropped so the finishing image wins.
  assign start_acc = (state_q == ST_IDLE) && start && !done_q;

  // Next-state, counters, window handshake and weight-memory read decode.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    fc_idx_d  = fc_idx_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    win_ready = 1'b0;
    wmem_rd   = 1'b0;
    wmem_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d   = ST_KLOAD;
          win_cnt_d = '0;
          fc_idx_d  = '0;
          cnt_clr   = 1'b1;
        end
      end

      ST_KLOAD: begin
        wmem_rd   = 1'b1;
        wmem_addr = KSET_A;
        state_d   = ST_CONV;
        if (dp_weight_req) err_d = 1'b1;
      end

      ST_CONV: begin
        // The window count gate keeps a 82nd window from ever reaching the datapath.
        win_ready = win_valid && (win_cnt_q < WIN_END);
        if (win_ready) begin
          win_cnt_d = win_cnt_q + FADDR_W'(1);
          if (win_cnt_q == WIN_LAST) state_d = ST_FC;
        end
        if (dp_weight_req) err_d = 1'b1;
      end

      ST_FC: begin
        // Read issued with the request so the data lands in the datapath FC cycle;
        // the datapath's trailing request after the last set gets no read.
        if (dp_weight_req && (fc_idx_q < FC_END)) begin
          wmem_rd   = 1'b1;
          wmem_addr = FC_BASE_A + WADDR_W'(fc_idx_q);
          fc_idx_d  = fc_idx_q + RADDR_W'(1);
        end
        if (fc_idx_q == FC_END) state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (res_cnt == FC_END) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (busy && ((dp_out_conv_valid && (f_cnt == WIN_END)) ||
                 (dp_out_fc_valid && (res_cnt == FC_END)))) begin
      err_d = 1'b1;
    end
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      fc_idx_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      fc_idx_q  <= fc_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  bnn_wr_addr_gen #(
    .ADDR_W (FADDR_W),
    .DEPTH  (WIN_NUM)
  ) u_fbuf_gen (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (cnt_clr),
    .en     (busy),
    .vld_in (dp_out_conv_valid),
    .we     (fbuf_we),
    .addr   (fbuf_addr),
    .cnt    (f_cnt)
  );

  bnn_wr_addr_gen #(
    .ADDR_W (RADDR_W),
    .DEPTH  (FC_NUM)
  ) u_res_gen (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (cnt_clr),
    .en     (busy),
    .vld_in (dp_out_fc_valid),
    .we     (res_we),
    .addr   (res_addr),
    .cnt    (res_cnt)
  );

`ifdef BNN_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Cycle count from KLOAD through the done cycle, saturating, held until next start.
  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if ((busy || done_q) && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
